// File: rtl/guess_if.sv
// guess_if: buttons, feedback scores and game results exchanged with guess_controller.
interface guess_if #(parameter int TURN_W = 4);
    logic              btn_inc, btn_next, btn_submit;
    logic [1:0]        fb1, fb2, fb3, fb4;
    logic [2:0]        guess1, guess2, guess3, guess4;
    logic [1:0]        sel;
    logic [TURN_W-1:0] turn;
    logic [1:0]        res1, res2, res3, res4;
    logic              win, lose, new_game;
    logic [TURN_W-1:0] hist_idx;
    logic [11:0]       hist_guess;
    logic [7:0]        hist_fb;
    modport master (
        output btn_inc, btn_next, btn_submit, fb1, fb2, fb3, fb4, hist_idx,
        input  guess1, guess2, guess3, guess4, sel, turn, res1, res2, res3, res4,
               win, lose, new_game, hist_guess, hist_fb
    );
    modport slave (
        input  btn_inc, btn_next, btn_submit, fb1, fb2, fb3, fb4, hist_idx,
        output guess1, guess2, guess3, guess4, sel, turn, res1, res2, res3, res4,
               win, lose, new_game, hist_guess, hist_fb
    );
endinterface

// File: rtl/guess_controller.sv
// guess_controller: Mastermind player side - guess entry, feedback capture, turn count, win/lose.
// Optional per-turn guess/feedback history enabled by defining GUESS_HISTORY_EN.
module guess_controller #(
    parameter int NUM_COLORS = 6,
    parameter int MAX_TURNS  = 10,
    parameter int TURN_W     = 4
) (
    input logic   clk,
    input logic   rst,
    guess_if.slave bus
);
    typedef enum logic [2:0] {ENTRY, EVAL, CHECK, WIN, LOSE} state_t;
    localparam logic [2:0]        CMAX = 3'(NUM_COLORS - 1);
    localparam logic [TURN_W-1:0] LAST = TURN_W'(MAX_TURNS - 1);
    state_t            state, state_n;
    logic [2:0]        g [4];
    logic [1:0]        r [4];
    logic [1:0]        sel;
    logic [TURN_W-1:0] turn;
    logic              ng, all_exact, restart;
    assign all_exact = bus.fb1 == 2'd2 && bus.fb2 == 2'd2 && bus.fb3 == 2'd2 && bus.fb4 == 2'd2;
    assign restart   = (state == WIN || state == LOSE) && bus.btn_submit;
    always_ff @(posedge clk) state <= rst ? ENTRY : state_n;
    always_comb begin
        state_n = state;
        case (state)
            ENTRY:   state_n = bus.btn_submit ? EVAL : ENTRY;
            EVAL:    state_n = CHECK;
            CHECK:   state_n = all_exact ? WIN : (turn == LAST) ? LOSE : ENTRY;
            default: state_n = bus.btn_submit ? ENTRY : state;
        endcase
    end
    always_ff @(posedge clk) begin
        ng <= rst || restart;
        if (rst || restart) begin
            g    <= '{default: '0};
            r    <= '{default: '0};
            sel  <= '0;
            turn <= '0;
        end else if (state == ENTRY && !bus.btn_submit) begin
            if (bus.btn_next)
                sel <= sel + 2'd1;
            else if (bus.btn_inc)
                g[sel] <= (g[sel] == CMAX) ? 3'd0 : g[sel] + 3'd1;
        end else if (state == CHECK) begin
            r    <= '{bus.fb1, bus.fb2, bus.fb3, bus.fb4};
            turn <= turn + 1'b1;
            if (!all_exact && turn != LAST)
                sel <= '0;
        end
    end
    assign bus.guess1   = g[0];
    assign bus.guess2   = g[1];
    assign bus.guess3   = g[2];
    assign bus.guess4   = g[3];
    assign bus.res1     = r[0];
    assign bus.res2     = r[1];
    assign bus.res3     = r[2];
    assign bus.res4     = r[3];
    assign bus.sel      = sel;
    assign bus.turn     = turn;
    assign bus.win      = state == WIN;
    assign bus.lose     = state == LOSE;
    assign bus.new_game = ng;
`ifdef GUESS_HISTORY_EN
    logic [11:0] hg [MAX_TURNS];
    logic [7:0]  hf [MAX_TURNS];
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            hg <= '{default: '0};
            hf <= '{default: '0};
        end else if (state == CHECK) begin
            hg[turn] <= {g[0], g[1], g[2], g[3]};
            hf[turn] <= {bus.fb1, bus.fb2, bus.fb3, bus.fb4};
        end
    end
    // Entries not yet written this game read as zero regardless of stale contents
    assign bus.hist_guess = (bus.hist_idx < turn) ? hg[bus.hist_idx] : '0;
    assign bus.hist_fb    = (bus.hist_idx < turn) ? hf[bus.hist_idx] : '0;
`else
    logic unused_idx;
    assign unused_idx     = ^bus.hist_idx;
    assign bus.hist_guess = '0;
    assign bus.hist_fb    = '0;
`endif
endmodule

// File: tb/tb_guess_controller.sv
// tb_guess_controller: directed checks of guess entry, latency, wrap, win/lose, reset and history.
module tb_guess_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    always #5 clk = ~clk;
    guess_if #(.TURN_W(4)) bus();
    guess_controller #(.NUM_COLORS(6), .MAX_TURNS(10), .TURN_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    wire [11:0] gs = {bus.guess1, bus.guess2, bus.guess3, bus.guess4};
    wire [7:0]  rs = {bus.res1, bus.res2, bus.res3, bus.res4};

    task automatic press(input logic i, input logic n, input logic s);
        bus.btn_inc = i; bus.btn_next = n; bus.btn_submit = s;
        @(posedge clk); #1;
        bus.btn_inc = 0; bus.btn_next = 0; bus.btn_submit = 0;
    endtask

    task automatic submit(input logic [7:0] fb);
        {bus.fb1, bus.fb2, bus.fb3, bus.fb4} = fb;
        press(0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.btn_inc = 0; bus.btn_next = 0; bus.btn_submit = 0;
        {bus.fb1, bus.fb2, bus.fb3, bus.fb4} = '0;
        bus.hist_idx = '0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        checks++; if (bus.new_game !== 1'b1) begin failures++; $display("FAIL reset_new_game got=%0d exp=1", bus.new_game); end
        checks++; if ({gs, rs, bus.sel, bus.turn, bus.win, bus.lose} !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", {gs, rs, bus.sel, bus.turn, bus.win, bus.lose}); end
        @(posedge clk); #1;
        checks++; if (bus.new_game !== 1'b0) begin failures++; $display("FAIL reset_new_game_drop got=%0d exp=0", bus.new_game); end
    endtask

    task automatic test_entry_latency;
        repeat (3) press(1, 0, 0);
        press(0, 1, 0);
        press(1, 0, 0);
        checks++; if (gs !== {3'd3, 3'd1, 6'd0}) begin failures++; $display("FAIL entry_guess got=%h exp=%h", gs, {3'd3, 3'd1, 6'd0}); end
        checks++; if (bus.sel !== 2'd1) begin failures++; $display("FAIL entry_sel got=%0d exp=1", bus.sel); end
        {bus.fb1, bus.fb2, bus.fb3, bus.fb4} = {2'd1, 2'd2, 2'd0, 2'd1};
        press(0, 0, 1);
        checks++; if ({rs, bus.turn} !== '0) begin failures++; $display("FAIL eval_no_update got=%h exp=0", {rs, bus.turn}); end
        bus.btn_inc = 1; bus.btn_next = 1;
        @(posedge clk); #1;
        checks++; if ({rs, bus.turn} !== '0) begin failures++; $display("FAIL check_not_yet got=%h exp=0", {rs, bus.turn}); end
        @(posedge clk); #1;
        bus.btn_inc = 0; bus.btn_next = 0;
        checks++; if (rs !== {2'd1, 2'd2, 2'd0, 2'd1}) begin failures++; $display("FAIL latency_res got=%h exp=%h", rs, {2'd1, 2'd2, 2'd0, 2'd1}); end
        checks++; if (bus.turn !== 4'd1) begin failures++; $display("FAIL latency_turn got=%0d exp=1", bus.turn); end
        checks++; if (gs !== {3'd3, 3'd1, 6'd0}) begin failures++; $display("FAIL frozen_guess got=%h exp=%h", gs, {3'd3, 3'd1, 6'd0}); end
        checks++; if (bus.sel !== 2'd0) begin failures++; $display("FAIL sel_cleared got=%0d exp=0", bus.sel); end
    endtask

    task automatic test_wrap;
        repeat (2) press(1, 0, 0);
        checks++; if (bus.guess1 !== 3'd5) begin failures++; $display("FAIL color_max got=%0d exp=5", bus.guess1); end
        press(1, 0, 0);
        checks++; if (bus.guess1 !== 3'd0) begin failures++; $display("FAIL color_wrap got=%0d exp=0", bus.guess1); end
        repeat (3) press(0, 1, 0);
        checks++; if (bus.sel !== 2'd3) begin failures++; $display("FAIL sel_max got=%0d exp=3", bus.sel); end
        press(0, 1, 0);
        checks++; if (bus.sel !== 2'd0) begin failures++; $display("FAIL sel_wrap got=%0d exp=0", bus.sel); end
        press(1, 1, 0);
        checks++; if ({gs, bus.sel} !== {3'd0, 3'd1, 6'd0, 2'd1}) begin failures++; $display("FAIL next_over_inc got=%h exp=%h", {gs, bus.sel}, {3'd0, 3'd1, 6'd0, 2'd1}); end
    endtask

    task automatic test_win;
        submit(8'h00);
        submit(8'h00);
        checks++; if ({bus.turn, bus.win} !== {4'd3, 1'b0}) begin failures++; $display("FAIL pre_win got=%h exp=%h", {bus.turn, bus.win}, {4'd3, 1'b0}); end
        submit(8'hAA);
        checks++; if ({bus.win, bus.lose, bus.turn} !== {1'b1, 1'b0, 4'd4}) begin failures++; $display("FAIL win_turn4 got=%h exp=%h", {bus.win, bus.lose, bus.turn}, {1'b1, 1'b0, 4'd4}); end
        checks++; if (rs !== 8'hAA) begin failures++; $display("FAIL win_res got=%h exp=aa", rs); end
        press(1, 0, 0);
        press(0, 1, 0);
        checks++; if ({gs, bus.sel, bus.win} !== {3'd0, 3'd1, 6'd0, 2'd0, 1'b1}) begin failures++; $display("FAIL win_ignores_btn got=%h exp=%h", {gs, bus.sel, bus.win}, {3'd0, 3'd1, 6'd0, 2'd0, 1'b1}); end
        press(0, 0, 1);
        checks++; if (bus.new_game !== 1'b1) begin failures++; $display("FAIL restart_new_game got=%0d exp=1", bus.new_game); end
        checks++; if ({gs, rs, bus.sel, bus.turn, bus.win, bus.lose} !== '0) begin failures++; $display("FAIL restart_cleared got=%h exp=0", {gs, rs, bus.sel, bus.turn, bus.win, bus.lose}); end
        @(posedge clk); #1;
        checks++; if (bus.new_game !== 1'b0) begin failures++; $display("FAIL restart_pulse_len got=%0d exp=0", bus.new_game); end
    endtask

    task automatic test_lose;
        repeat (9) submit(8'h40);
        checks++; if ({bus.turn, bus.lose, bus.win} !== {4'd9, 2'b00}) begin failures++; $display("FAIL pre_lose got=%h exp=%h", {bus.turn, bus.lose, bus.win}, {4'd9, 2'b00}); end
        submit(8'h40);
        checks++; if ({bus.turn, bus.lose, bus.win} !== {4'd10, 2'b10}) begin failures++; $display("FAIL lose_turn10 got=%h exp=%h", {bus.turn, bus.lose, bus.win}, {4'd10, 2'b10}); end
        press(0, 0, 1);
        checks++; if ({bus.turn, bus.lose, bus.new_game} !== {4'd0, 2'b01}) begin failures++; $display("FAIL lose_restart got=%h exp=%h", {bus.turn, bus.lose, bus.new_game}, {4'd0, 2'b01}); end
        repeat (9) submit(8'h40);
        submit(8'hAA);
        checks++; if ({bus.turn, bus.lose, bus.win} !== {4'd10, 2'b01}) begin failures++; $display("FAIL win_last_turn got=%h exp=%h", {bus.turn, bus.lose, bus.win}, {4'd10, 2'b01}); end
        press(0, 0, 1);
    endtask

    task automatic test_rst_mid_eval;
        submit(8'h40);
        checks++; if (bus.turn !== 4'd1) begin failures++; $display("FAIL rst_setup_turn got=%0d exp=1", bus.turn); end
        {bus.fb1, bus.fb2, bus.fb3, bus.fb4} = 8'hAA;
        press(0, 0, 1);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        checks++; if ({rs, bus.turn, bus.win, bus.new_game} !== {8'h00, 4'd0, 2'b01}) begin failures++; $display("FAIL rst_mid_eval got=%h exp=%h", {rs, bus.turn, bus.win, bus.new_game}, {8'h00, 4'd0, 2'b01}); end
        @(posedge clk); #1;
        checks++; if ({rs, bus.turn, bus.win} !== '0) begin failures++; $display("FAIL rst_no_late_check got=%h exp=0", {rs, bus.turn, bus.win}); end
        bus.hist_idx = 4'd0; #1;
        checks++; if ({bus.hist_guess, bus.hist_fb} !== '0) begin failures++; $display("FAIL rst_no_history got=%h exp=0", {bus.hist_guess, bus.hist_fb}); end
    endtask

    task automatic test_history;
        logic [11:0] eg [4];
        logic [7:0]  ef [4];
`ifdef GUESS_HISTORY_EN
        eg = '{{3'd1, 9'd0}, {3'd2, 9'd0}, {3'd2, 3'd1, 6'd0}, 12'd0};
        ef = '{8'b01000000, 8'b10010000, 8'b00000110, 8'd0};
`else
        eg = '{default: '0};
        ef = '{default: '0};
`endif
        press(1, 0, 0);
        submit(8'b01000000);
        press(1, 0, 0);
        submit(8'b10010000);
        press(0, 1, 0);
        press(1, 0, 0);
        submit(8'b00000110);
        checks++; if (bus.turn !== 4'd3) begin failures++; $display("FAIL hist_turn got=%0d exp=3", bus.turn); end
        for (int i = 0; i < 4; i++) begin
            bus.hist_idx = 4'(i); #1;
            checks++; if (bus.hist_guess !== eg[i]) begin failures++; $display("FAIL hist_guess[%0d] got=%h exp=%h", i, bus.hist_guess, eg[i]); end
            checks++; if (bus.hist_fb !== ef[i]) begin failures++; $display("FAIL hist_fb[%0d] got=%h exp=%h", i, bus.hist_fb, ef[i]); end
        end
    endtask

    initial begin
        test_reset;
        test_entry_latency;
        test_wrap;
        test_win;
        test_lose;
        test_rst_mid_eval;
        test_history;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
